bus_transfer_sequencer: RTL

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

---
 rtl/bus_transfer_sequencer_pkg.sv | 15 +
 rtl/bus_transfer_sequencer_fifo.sv | 48 ++++
 rtl/bus_transfer_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared definitions for the bus transfer sequencer: FSM state encoding and
// default geometry of the register bus.
package bus_transfer_sequencer_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH,
    ST_RELEASE
  } xfer_state_t;

endpackage

// File: rtl/bus_transfer_sequencer_fifo.sv
// Two-entry request FIFO with a combinational head. The owner must only push
// when not full (or when popping in the same cycle) and only pop when non-empty.
module xfer_req_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             register_clock,
  input  logic             register_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;

  // Storage carries no reset so it maps onto plain memory cells.
  always_ff @(posedge register_clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge register_clock) begin
    if (!register_reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign empty     = (count_reg == 2'd0);
  assign full      = (count_reg == 2'd2);

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register and immediate-to-register moves over a shared
// bus: drive the source, latch into the destination, release, one per 4 cycles.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                        register_clock,
  input  logic                        register_reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_REGS)-1:0] req_src,
  input  logic [$clog2(NUM_REGS)-1:0] req_dst,
  input  logic                        req_imm_sel,
  input  logic [DATA_W-1:0]           req_imm,
  output logic [NUM_REGS-1:0]         bus_out_en,
  output logic [NUM_REGS-1:0]         bus_in_en,
  output logic [DATA_W-1:0]           bus_imm_out,
  output logic                        bus_imm_out_en,
  output logic                        done,
  output logic                        err,
  output logic                        busy
);

  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int ENTRY_W = 2 * IDX_W + 1 + DATA_W;
  localparam logic [IDX_W:0] NUM_REGS_W = NUM_REGS[IDX_W:0];

  xfer_state_t         state_reg;
  logic [NUM_REGS-1:0] bus_out_en_reg;
  logic [NUM_REGS-1:0] bus_in_en_reg;
  logic [NUM_REGS-1:0] dst_onehot_reg;
  logic [DATA_W-1:0]   imm_out_reg;
  logic                imm_en_reg;
  logic                done_reg;
  logic                err_reg;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [ENTRY_W-1:0]  head;
  logic                head_imm_sel;
  logic [IDX_W-1:0]    head_src;
  logic [IDX_W-1:0]    head_dst;
  logic [DATA_W-1:0]   head_imm;
  logic                head_legal;
  logic [NUM_REGS-1:0] src_onehot;
  logic [NUM_REGS-1:0] dst_onehot;

  // A pop frees a slot in the same cycle, so a full queue still accepts then.
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
  assign req_ready = register_reset && (!fifo_full || fifo_pop);
  assign fifo_push = req_valid && req_ready;

  xfer_req_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .register_clock(register_clock),
    .register_reset(register_reset),
    .push          (fifo_push),
    .push_data     ({req_imm_sel, req_src, req_dst, req_imm}),
    .pop           (fifo_pop),
    .head_data     (head),
    .empty         (fifo_empty),
    .full          (fifo_full)
  );

  assign head_imm_sel = head[ENTRY_W-1];
  assign head_src     = head[ENTRY_W-2 -: IDX_W];
  assign head_dst     = head[DATA_W +: IDX_W];
  assign head_imm     = head[DATA_W-1:0];

  // Immediate moves ignore src; register moves need two distinct in-range indices.
  assign head_legal = ({1'b0, head_dst} < NUM_REGS_W) &&
                      (head_imm_sel ||
                       (({1'b0, head_src} < NUM_REGS_W) && (head_src != head_dst)));

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
    localparam logic [IDX_W-1:0] IDX = IDX_W'(gi);
    assign src_onehot[gi] = (head_src == IDX);
    assign dst_onehot[gi] = (head_dst == IDX);
  end

  always_ff @(posedge register_clock) begin
    if (!register_reset) begin
      state_reg      <= ST_IDLE;
      bus_out_en_reg <= '0;
      bus_in_en_reg  <= '0;
      dst_onehot_reg <= '0;
      imm_out_reg    <= '0;
      imm_en_reg     <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fifo_pop) begin
            if (head_legal) begin
              state_reg      <= ST_DRIVE;
              dst_onehot_reg <= dst_onehot;
              if (head_imm_sel) begin
                imm_en_reg  <= 1'b1;
                imm_out_reg <= head_imm;
              end else begin
                bus_out_en_reg <= src_onehot;
              end
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          state_reg     <= ST_LATCH;
          bus_in_en_reg <= dst_onehot_reg;
        end
        ST_LATCH: begin
          state_reg      <= ST_RELEASE;
          bus_out_en_reg <= '0;
          bus_in_en_reg  <= '0;
          imm_en_reg     <= 1'b0;
          imm_out_reg    <= '0;
          done_reg       <= 1'b1;
        end
        ST_RELEASE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_out_en     = bus_out_en_reg;
  assign bus_in_en      = bus_in_en_reg;
  assign bus_imm_out    = imm_out_reg;
  assign bus_imm_out_en = imm_en_reg;
  assign done           = done_reg;
  assign err            = err_reg;
  assign busy           = (state_reg != ST_IDLE) || !fifo_empty;

endmodule
